// File: rtl/quad_step_decoder.sv
// ----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for the 4-bit up/down counter. Turns a 2-phase quadrature encoder
// (asynchronous to clk_i) into a one-cycle step pulse plus a direction level.
// Illegal double-edge transitions are never turned into steps. They set a
// sticky flag and increment a saturating counter.
//
// Optional feature macro: GLITCH_FILTER_EN
//   defined   : per-phase glitch filter after the synchronizer. A filtered bit
//               changes only after FILT_LEN consecutive identical samples.
//   undefined : the decoded pair comes straight from the last sync flop.
//
// Parameters
//   SYNC_STAGES  synchronizer flops per input (>= 2)
//   FILT_LEN     consecutive equal samples needed by the filter (>= 2)
//   ERR_W        width of err_cnt_o
//
// Ports
//   clk_i      in   1      clock, all state on posedge
//   rst_ni     in   1      asynchronous active-low reset
//   enc_a_i    in   1      encoder phase A (asynchronous)
//   enc_b_i    in   1      encoder phase B (asynchronous)
//   clr_err_i  in   1      synchronous clear of err_o / err_cnt_o
//   step_o     out  1      one-cycle pulse per legal quadrature transition
//   up_down_o  out  1      direction of the most recent legal step (1 = up)
//   err_o      out  1      sticky: an illegal transition has been seen
//   err_cnt_o  out  ERR_W  count of illegal transitions, saturating
// ----------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             clr_err_i,
    output logic             step_o,
    output logic             up_down_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

`ifdef GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    // INIT lasts long enough to flush the reset value out of the input path.
    localparam int INIT_CYCLES = SYNC_STAGES + (FILT_EN ? FILT_LEN : 0);
    localparam int ICW         = $clog2(INIT_CYCLES + 1);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
    logic [1:0]             rawPair;
    logic [1:0]             samplePair;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[SYNC_STAGES-2:0], enc_a_i};
            syncB_q <= {syncB_q[SYNC_STAGES-2:0], enc_b_i};
        end
    end

    assign rawPair = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

`ifdef GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN);

    logic [1:0]     filt_q;
    logic [FCW-1:0] filtCnt_q [2];

    // The counter tracks how many samples in a row have differed from the
    // filtered value. The filtered value flips on the FILT_LEN-th such sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q       <= '0;
            filtCnt_q[0] <= '0;
            filtCnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rawPair[i] != filt_q[i]) begin
                    if (filtCnt_q[i] == FCW'(FILT_LEN - 1)) begin
                        filt_q[i]    <= rawPair[i];
                        filtCnt_q[i] <= '0;
                    end else begin
                        filtCnt_q[i] <= filtCnt_q[i] + FCW'(1);
                    end
                end else begin
                    filtCnt_q[i] <= '0;
                end
            end
        end
    end

    assign samplePair = filt_q;
`else
    assign samplePair = rawPair;
`endif

    state_t           state_q;
    logic [ICW-1:0]   initCnt_q;
    logic [1:0]       prev_q;
    logic             step_q, upDown_q, err_q;
    logic [ERR_W-1:0] errCnt_q;

    logic [1:0]       posNow, posPrev, posDelta;
    logic             isFwd, isBwd, isDbl;
    logic             err_d;
    logic [ERR_W-1:0] errCnt_d;

    // Map Gray code to a linear position (00,01,11,10 -> 0,1,2,3). The modulo-4
    // difference is then +1 forward, -1 backward, 2 for a double edge.
    always_comb begin
        posNow   = {samplePair[1], samplePair[1] ^ samplePair[0]};
        posPrev  = {prev_q[1], prev_q[1] ^ prev_q[0]};
        posDelta = posNow - posPrev;
        isFwd    = (posDelta == 2'd1);
        isBwd    = (posDelta == 2'd3);
        isDbl    = (posDelta == 2'd2);
    end

    // A new illegal event overrides a clear issued in the same cycle, so the
    // count restarts at 1 instead of being lost.
    always_comb begin
        err_d    = err_q;
        errCnt_d = errCnt_q;
        if (clr_err_i) begin
            err_d    = 1'b0;
            errCnt_d = '0;
        end
        if (state_q == TRACK && isDbl) begin
            err_d = 1'b1;
            if (clr_err_i) begin
                errCnt_d = ERR_W'(1);
            end else if (errCnt_q != '1) begin
                errCnt_d = errCnt_q + ERR_W'(1);
            end
        end
    end

    // INIT never issues step or err. On expiry it adopts the current input
    // position as the reference so that the reset value cannot produce a step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            initCnt_q <= ICW'(INIT_CYCLES);
            prev_q    <= 2'b00;
            step_q    <= 1'b0;
            upDown_q  <= 1'b1;
            err_q     <= 1'b0;
            errCnt_q  <= '0;
        end else begin
            step_q   <= 1'b0;
            err_q    <= err_d;
            errCnt_q <= errCnt_d;
            case (state_q)
                INIT: begin
                    if (initCnt_q == '0) begin
                        prev_q  <= samplePair;
                        state_q <= TRACK;
                    end else begin
                        initCnt_q <= initCnt_q - ICW'(1);
                    end
                end
                TRACK: begin
                    if (isFwd) begin
                        step_q   <= 1'b1;
                        upDown_q <= 1'b1;
                        prev_q   <= samplePair;
                    end else if (isBwd) begin
                        step_q   <= 1'b1;
                        upDown_q <= 1'b0;
                        prev_q   <= samplePair;
                    end else if (isDbl) begin
                        prev_q <= samplePair;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign step_o    = step_q;
    assign up_down_o = upDown_q;
    assign err_o     = err_q;
    assign err_cnt_o = errCnt_q;

endmodule
